// File: rtl/ifetch_queue.sv
// Instruction fetch queue: in-order req/gnt fetch into a DEPTH-entry prefetch FIFO.
// Optional perf counters when IFQ_PERF_EN is defined.
module ifetch_queue #(
  parameter int              ADDR_W   = 16,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_v_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              inst_rdy_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] baddr_i
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_flush_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t [DEPTH-1:0] fifo;
  logic [ADDR_W-1:0]  pc_r;
  logic               init_r;
  logic [CW-1:0]      inflight, drop, count, live;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic               credit, grant, push, pop;
  logic [ADDR_W-1:0]  resp_pc;

  assign credit      = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(DEPTH);
  assign imem_req_o  = init_r & ~branch_i & credit;
  assign imem_addr_o = pc_r;
  assign grant       = imem_req_o & imem_gnt_i;

  assign inst_v_o = (count != '0) & ~branch_i;
  assign pop      = inst_v_o & inst_rdy_i;
  assign push     = imem_rvalid_i & ~branch_i & (drop == '0);
  assign inst_o   = fifo[rd_ptr].inst;
  assign pc_o     = fifo[rd_ptr].pc;

  // Live (non-dropped) requests are contiguous and end just below pc_r,
  // so the oldest one's address is recovered without a tag FIFO.
  assign live    = inflight - drop;
  assign resp_pc = pc_r - ADDR_W'(live);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      init_r   <= 1'b0;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      init_r   <= 1'b1;
      inflight <= inflight + CW'(grant) - CW'(imem_rvalid_i);
      if (branch_i) begin
        pc_r   <= baddr_i;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        // a response landing this cycle is already discarded, so it is not counted
        drop   <= inflight - CW'(imem_rvalid_i);
      end else begin
        if (grant) pc_r <= pc_r + 1'b1;
        if (imem_rvalid_i && drop != '0) drop <= drop - 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= entry_t'{pc: resp_pc, inst: imem_rdata_i};
  end

`ifdef IFQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_o <= '0;
      perf_flush_o <= '0;
    end else begin
      if (inst_rdy_i && !inst_v_o && init_r && perf_stall_o != '1)
        perf_stall_o <= perf_stall_o + 1'b1;
      if (branch_i && perf_flush_o != '1)
        perf_flush_o <= perf_flush_o + 1'b1;
    end
  end
`endif

endmodule
